// File: rtl/spi_host_tx_unpacker_if.sv
// spi_host_tx_unpacker_if: word-in / byte-out handshake bundle for the SPI host TX unpacker.
interface spi_host_tx_unpacker_if;
    logic [31:0] word_data_i;
    logic [3:0]  word_be_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [7:0]  byte_data_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic        byte_last_o;
    logic        be_zero_o;
    logic [15:0] bytes_sent_o;
    modport master (
        output word_data_i, word_be_i, word_valid_i, byte_ready_i,
        input  word_ready_o, byte_data_o, byte_valid_o, byte_last_o, be_zero_o, bytes_sent_o
    );
    modport slave (
        input  word_data_i, word_be_i, word_valid_i, byte_ready_i,
        output word_ready_o, byte_data_o, byte_valid_o, byte_last_o, be_zero_o, bytes_sent_o
    );
endinterface

// File: rtl/spi_host_tx_unpacker.sv
// spi_host_tx_unpacker: splits byte-enabled 32-bit TX words into a byte stream, one byte per cycle.
module spi_host_tx_unpacker #(
    parameter logic SwapBytes = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sw_rst_i,
    spi_host_tx_unpacker_if.slave    bus
);
    logic [31:0] data_q;
    logic [3:0]  mask_q;
    logic        be_zero_q;
    logic [15:0] cnt_q;
    logic [1:0]  lane;
    logic        last;
    logic        byte_fire;
    logic        word_fire;
    // Presented lane is the first remaining enabled lane in emission order.
    always_comb begin
        lane = SwapBytes ? (mask_q[3] ? 2'd3 : mask_q[2] ? 2'd2 : mask_q[1] ? 2'd1 : 2'd0)
                         : (mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : mask_q[2] ? 2'd2 : 2'd3);
    end
    assign last             = (mask_q != 4'd0) && ((mask_q & (mask_q - 4'd1)) == 4'd0);
    assign bus.byte_valid_o = |mask_q;
    assign bus.byte_data_o  = bus.byte_valid_o ? data_q[{lane, 3'b000} +: 8] : 8'h00;
    assign bus.byte_last_o  = last;
    // Refill in the same cycle the final byte leaves, so words stream without bubbles.
    assign bus.word_ready_o = !sw_rst_i && (!bus.byte_valid_o || (last && bus.byte_ready_i));
    assign bus.be_zero_o    = be_zero_q;
    assign bus.bytes_sent_o = cnt_q;
    assign byte_fire        = bus.byte_valid_o && bus.byte_ready_i && !sw_rst_i;
    assign word_fire        = bus.word_valid_i && bus.word_ready_o;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= 32'h0;
            mask_q    <= 4'h0;
            be_zero_q <= 1'b0;
            cnt_q     <= 16'h0;
        end else if (sw_rst_i) begin
            data_q    <= 32'h0;
            mask_q    <= 4'h0;
            be_zero_q <= 1'b0;
            cnt_q     <= 16'h0;
        end else begin
            if (word_fire) begin
                data_q <= bus.word_data_i;
                mask_q <= bus.word_be_i;
            end else if (byte_fire) begin
                mask_q <= mask_q & ~(4'b0001 << lane);
            end
            be_zero_q <= word_fire && (bus.word_be_i == 4'h0);
            cnt_q     <= cnt_q + {15'd0, byte_fire};
        end
    end
endmodule

// File: tb/tb_spi_host_tx_unpacker.sv
// tb_spi_host_tx_unpacker: vector table plus directed sequences for the TX unpacker.
module tb_spi_host_tx_unpacker;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic sw0 = 1'b0;
    logic sw1 = 1'b0;
    int   tests = 0;
    int   fails = 0;
    always #5 clk_i = ~clk_i;
    spi_host_tx_unpacker_if b0();
    spi_host_tx_unpacker_if b1();
    spi_host_tx_unpacker #(.SwapBytes(1'b0)) u0 (.clk_i(clk_i), .rst_i(rst_i), .sw_rst_i(sw0), .bus(b0.slave));
    spi_host_tx_unpacker #(.SwapBytes(1'b1)) u1 (.clk_i(clk_i), .rst_i(rst_i), .sw_rst_i(sw1), .bus(b1.slave));
    typedef struct {
        logic [31:0] d;
        logic [3:0]  be;
        logic        wv, br, sw;
        logic        bv;
        logic [7:0]  bd;
        logic        bl, wr, bz;
        logic [15:0] cnt;
    } vec_t;
    vec_t tv[24];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic chk_idle(input string nm);
        chk({nm, "_bv"}, {31'd0, b0.byte_valid_o}, 32'd0);
        chk({nm, "_bd"}, {24'd0, b0.byte_data_o}, 32'd0);
        chk({nm, "_bl"}, {31'd0, b0.byte_last_o}, 32'd0);
        chk({nm, "_wr"}, {31'd0, b0.word_ready_o}, 32'd1);
        chk({nm, "_bz"}, {31'd0, b0.be_zero_o}, 32'd0);
        chk({nm, "_cnt"}, {16'd0, b0.bytes_sent_o}, 32'd0);
    endtask
    initial begin
        logic [7:0] exp1[8];
        int n;
        // d, be, wv, br, sw | bv, bd, bl, wr, bz, cnt
        tv[0]  = '{32'hA1B2C3D4, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
        tv[1]  = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD4, 1'b0, 1'b0, 1'b0, 16'd0};
        tv[2]  = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 16'd1};
        tv[3]  = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 16'd2};
        tv[4]  = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 16'd3};
        tv[5]  = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd4};
        tv[6]  = '{32'h55667788, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd4};
        tv[7]  = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 16'd4};
        tv[8]  = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 16'd5};
        tv[9]  = '{32'h99999999, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd6};
        tv[10] = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd6};
        tv[11] = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd6};
        tv[12] = '{32'h01020304, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd6};
        for (int i = 13; i < 18; i++)
            tv[i] = '{32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 16'd6};
        tv[18] = '{32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 16'd6};
        tv[19] = '{32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 16'd7};
        tv[20] = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 16'd8};
        tv[21] = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b0, 1'b0, 16'd9};
        tv[22] = '{32'h12345678, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, 16'd10};
        tv[23] = '{32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
        exp1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
        b0.word_data_i = 32'h0; b0.word_be_i = 4'h0; b0.word_valid_i = 1'b0; b0.byte_ready_i = 1'b0;
        b1.word_data_i = 32'h0; b1.word_be_i = 4'h0; b1.word_valid_i = 1'b0; b1.byte_ready_i = 1'b0;
        #12;
        chk_idle("rst_hold");
        chk("rst_hold_u1_bv", {31'd0, b1.byte_valid_o}, 32'd0);
        step();
        rst_i = 1'b0;
        #1;
        chk_idle("rst_rel");
        step();
        for (int i = 0; i < 24; i++) begin
            b0.word_data_i = tv[i].d; b0.word_be_i = tv[i].be; b0.word_valid_i = tv[i].wv;
            b0.byte_ready_i = tv[i].br; sw0 = tv[i].sw;
            #1;
            chk($sformatf("v%0d_bv", i), {31'd0, b0.byte_valid_o}, {31'd0, tv[i].bv});
            chk($sformatf("v%0d_bd", i), {24'd0, b0.byte_data_o}, {24'd0, tv[i].bd});
            chk($sformatf("v%0d_bl", i), {31'd0, b0.byte_last_o}, {31'd0, tv[i].bl});
            chk($sformatf("v%0d_wr", i), {31'd0, b0.word_ready_o}, {31'd0, tv[i].wr});
            chk($sformatf("v%0d_bz", i), {31'd0, b0.be_zero_o}, {31'd0, tv[i].bz});
            chk($sformatf("v%0d_cnt", i), {16'd0, b0.bytes_sent_o}, {16'd0, tv[i].cnt});
            step();
        end
        b0.word_valid_i = 1'b0; b0.byte_ready_i = 1'b0; sw0 = 1'b0;
        // Descending order with back-to-back words: eight bytes on eight consecutive cycles.
        b1.word_data_i = 32'hA1B2C3D4; b1.word_be_i = 4'hF; b1.word_valid_i = 1'b1; b1.byte_ready_i = 1'b1;
        step();
        b1.word_data_i = 32'h11223344;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("swap_b%0d_bv", i), {31'd0, b1.byte_valid_o}, 32'd1);
            chk($sformatf("swap_b%0d_bd", i), {24'd0, b1.byte_data_o}, {24'd0, exp1[i]});
            if (i == 3) chk("swap_refill_wr", {31'd0, b1.word_ready_o}, 32'd1);
            if (i == 7) chk("swap_last", {31'd0, b1.byte_last_o}, 32'd1);
            step();
            if (i == 3) b1.word_valid_i = 1'b0;
        end
        chk("swap_cnt", {16'd0, b1.bytes_sent_o}, 32'd8);
        chk("swap_empty", {31'd0, b1.byte_valid_o}, 32'd0);
        // Asynchronous reset while a word is half drained.
        b0.word_data_i = 32'hA1B2C3D4; b0.word_be_i = 4'hF; b0.word_valid_i = 1'b1; b0.byte_ready_i = 1'b1;
        step();
        b0.word_valid_i = 1'b0;
        step();
        chk("mid_pre_bd", {24'd0, b0.byte_data_o}, 32'hC3);
        #2;
        rst_i = 1'b1;
        #1;
        chk_idle("mid_rst");
        step();
        rst_i = 1'b0;
        step();
        chk_idle("mid_after");
        // Counter wrap after 65536 byte transfers with words streaming continuously.
        n = 0;
        b0.word_data_i = 32'h0; b0.word_be_i = 4'hF; b0.word_valid_i = 1'b1; b0.byte_ready_i = 1'b1;
        for (int c = 0; c < 70000 && n < 65536; c++) begin
            if (b0.byte_valid_o && b0.byte_ready_i) n++;
            step();
            if (n == 65535 && b0.byte_valid_o) chk("wrap_ffff", {16'd0, b0.bytes_sent_o}, 32'hFFFF);
        end
        chk("wrap_count", n, 32'd65536);
        chk("wrap_zero", {16'd0, b0.bytes_sent_o}, 32'd0);
        b0.word_valid_i = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_host_tx_unpacker.md
SPI_HOST_TX_UNPACKER -- requirements
Module: spi_host_tx_unpacker

Interface
REQ-001 Parameter SwapBytes, default 1'b0: byte emission order; 0 emits byte lane 0 (bits 7:0) first, ascending; 1 emits byte lane 3 (bits 31:24) first, descending.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 sw_rst_i  input  1  synchronous software reset; flushes all state.
REQ-006 word_data_i  input  32  TX word from the data FIFO.
REQ-007 word_be_i  input  4  byte enables for word_data_i, bit n qualifies lane n.
REQ-008 word_valid_i  input  1  word handshake valid.
REQ-009 word_ready_o  output  1  word handshake ready.
REQ-010 byte_data_o  output  8  TX byte to the shift engine.
REQ-011 byte_valid_o  output  1  byte handshake valid.
REQ-012 byte_ready_i  input  1  byte handshake ready.
REQ-013 byte_last_o  output  1  high with byte_valid_o when the presented byte is the final enabled byte of its word.
REQ-014 be_zero_o  output  1  one-cycle pulse when a word with word_be_i==4'h0 is accepted.
REQ-015 bytes_sent_o  output  16  count of completed byte handshakes.

Function
REQ-016 The block SHALL hold at most one word in a 32-bit data register plus a 4-bit remaining-lane mask; states EMPTY (mask==0) and HOLD (mask!=0).
REQ-017 A word transfer SHALL occur when word_valid_i && word_ready_o; a byte transfer when byte_valid_o && byte_ready_i.
REQ-018 word_ready_o SHALL be 1 in EMPTY, and in HOLD only when the presented byte is last and byte_ready_i==1 (zero-bubble refill); word_ready_o SHALL be 0 while sw_rst_i==1.
REQ-019 On word transfer the register SHALL load word_data_i and the mask SHALL load word_be_i; the next state is HOLD if word_be_i!=0, else EMPTY.
REQ-020 byte_valid_o SHALL equal (mask!=0); no combinational path from word_valid_i to byte_valid_o or byte_data_o.
REQ-021 The presented lane SHALL be the first set mask bit in emission order (REQ-001); byte_data_o is that lane; byte_data_o is don't-care but SHALL be 8'h00 when byte_valid_o==0.
REQ-022 On byte transfer the presented lane's mask bit SHALL clear; non-contiguous enables (e.g. 4'b1010) are emitted in order, skipping disabled lanes, with no idle cycles.
REQ-023 byte_last_o SHALL be 1 iff exactly one mask bit is set.
REQ-024 Latency: a word accepted in cycle N presents its first byte in cycle N+1; sustained throughput is one byte per cycle across word boundaries.
REQ-025 be_zero_o SHALL assert for exactly the cycle after a word transfer with word_be_i==4'h0; the word produces no bytes.
REQ-026 bytes_sent_o SHALL increment by 1 per byte transfer, wrapping 16'hFFFF -> 16'h0000.
REQ-027 byte_valid_o held with no byte_ready_i SHALL keep byte_data_o and byte_last_o stable.
REQ-028 sw_rst_i==1 SHALL, at the next edge, clear mask, data register, be_zero_o and bytes_sent_o; a byte or word handshake coincident with sw_rst_i is discarded.

Reset
REQ-029 While rst_i==1 and after release: word_ready_o=1, byte_valid_o=0, byte_data_o=8'h00, byte_last_o=0, be_zero_o=0, bytes_sent_o=16'h0000, state EMPTY.
REQ-030 Reset assertion mid-word SHALL discard the held word with no further bytes emitted.

Verification
REQ-031 SwapBytes=0, word 32'hA1B2C3D4 be=4'hF, byte_ready_i=1 -> bytes D4,C3,B2,A1 in cycles N+1..N+4, byte_last_o only on A1, bytes_sent_o=4.
REQ-032 SwapBytes=1, same word, then 32'h11223344 be=4'hF back-to-back -> A1,B2,C3,D4,11,22,33,44 on 8 consecutive cycles, no bubble.
REQ-033 SwapBytes=0, be=4'b1010 on 32'h55667788 -> bytes 77 then 55; be=4'h0 -> no bytes, be_zero_o one-cycle pulse, word_ready_o stays 1.
REQ-034 byte_ready_i=0 for 5 cycles with word held -> byte_data_o stable, word_ready_o=0, word_valid_i backpressured; release -> normal drain.
REQ-035 sw_rst_i pulsed after second byte of a 4-byte word -> next cycle byte_valid_o=0, bytes_sent_o=0, no remaining bytes emitted; rst_i mid-word -> REQ-029 values immediately.
REQ-036 Preload bytes_sent_o scenario of 65536 byte transfers -> counter wraps to 16'h0000.
